// File: rtl/mem_bridge_pkg.sv
// ============================================================================
// Module      : mem_bridge_pkg
// Description : Shared widths, byte-select constants and FSM state encoding
//               for the core-to-byte-wide-memory bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bridge_pkg;

    localparam int DEF_ADR_W = 8;
    localparam int DEF_LO_W  = 8;
    localparam int DEF_HI_W  = 7;

    // Byte-select suffix appended to the core word address
    localparam logic LO_BYTE = 1'b0;
    localparam logic HI_BYTE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR    = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_bridge_if.sv
// ============================================================================
// Module      : mem_bridge_if
// Description : Core-side request port plus byte-wide external memory
//               req/ack port. slave = bridge view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bridge_if
    import mem_bridge_pkg::*;
#(
    parameter int ADR_W = DEF_ADR_W,
    parameter int LO_W  = DEF_LO_W,
    parameter int HI_W  = DEF_HI_W
) ();

    logic                 CoreReq;
    logic                 CoreWrite;
    logic [ADR_W-1:0]     CoreAdr;
    logic [LO_W-1:0]      CoreWData;
    logic                 CoreAck;
    logic [HI_W+LO_W-1:0] CoreRData;

    logic                 ExtReq;
    logic                 ExtWE;
    logic [ADR_W:0]       ExtAdr;
    logic [LO_W-1:0]      ExtWData;
    logic                 ExtAck;
    logic [LO_W-1:0]      ExtRData;

    modport slave (
        input  CoreReq, CoreWrite, CoreAdr, CoreWData, ExtAck, ExtRData,
        output CoreAck, CoreRData, ExtReq, ExtWE, ExtAdr, ExtWData
    );

    modport master (
        output CoreReq, CoreWrite, CoreAdr, CoreWData, ExtAck, ExtRData,
        input  CoreAck, CoreRData, ExtReq, ExtWE, ExtAdr, ExtWData
    );

endinterface

`default_nettype wire

// File: rtl/mem_bridge_word_cache.sv
// ============================================================================
// Module      : word_cache
// Description : One-entry last-read-word cache: combinational lookup,
//               fill on completed read, low-byte update on matching write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_cache #(
    parameter int ADR_W  = 8,
    parameter int LO_W   = 8,
    parameter int DATA_W = 15
) (
    input  wire logic              ph1,
    input  wire logic              reset,
    input  wire logic [ADR_W-1:0]  lookup_adr,
    output logic                   hit,
    output logic [DATA_W-1:0]      rdata,
    input  wire logic              fill_en,
    input  wire logic [ADR_W-1:0]  fill_adr,
    input  wire logic [DATA_W-1:0] fill_data,
    input  wire logic              upd_en,
    input  wire logic [ADR_W-1:0]  upd_adr,
    input  wire logic [LO_W-1:0]   upd_byte
);

    logic              valid_q, valid_d;
    logic [ADR_W-1:0]  tag_q,   tag_d;
    logic [DATA_W-1:0] data_q,  data_d;

    assign hit   = valid_q && (tag_q == lookup_adr);
    assign rdata = data_q;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_adr;
            data_d  = fill_data;
        end else if (upd_en && valid_q && (tag_q == upd_adr)) begin
            data_d[LO_W-1:0] = upd_byte;
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_bridge.sv
// ============================================================================
// Module      : mem_bridge
// Description : Splits core word reads into two byte transactions and core
//               writes into one, over a registered req/ack byte bus.
//               Optional last-word cache: MEM_BRIDGE_LAST_WORD_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADR_W = DEF_ADR_W,
    parameter int LO_W  = DEF_LO_W,
    parameter int HI_W  = DEF_HI_W
) (
    input  wire logic   ph1,
    input  wire logic   reset,
    mem_bridge_if.slave bus
);

    localparam int DATA_W = HI_W + LO_W;

    state_t            state_q,     state_d;
    logic              ext_req_q,   ext_req_d;
    logic              ext_we_q,    ext_we_d;
    logic [ADR_W:0]    ext_adr_q,   ext_adr_d;
    logic [LO_W-1:0]   ext_wdata_q, ext_wdata_d;
    logic              core_ack_q,  core_ack_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [LO_W-1:0]   lo_buf_q,    lo_buf_d;

    logic              ext_done;
    logic [DATA_W-1:0] read_word;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_word;

    // ExtAck only counts while our request is actually on the bus
    assign ext_done  = ext_req_q && bus.ExtAck;
    assign read_word = {bus.ExtRData[HI_W-1:0], lo_buf_q};

`ifdef MEM_BRIDGE_LAST_WORD_CACHE_EN
    word_cache #(
        .ADR_W  (ADR_W),
        .LO_W   (LO_W),
        .DATA_W (DATA_W)
    ) u_word_cache (
        .ph1        (ph1),
        .reset      (reset),
        .lookup_adr (bus.CoreAdr),
        .hit        (cache_hit),
        .rdata      (cache_word),
        .fill_en    ((state_q == RD_HI) && ext_done),
        .fill_adr   (bus.CoreAdr),
        .fill_data  (read_word),
        .upd_en     ((state_q == WR) && ext_done),
        .upd_adr    (bus.CoreAdr),
        .upd_byte   (ext_wdata_q)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_word = '0;
`endif

    always_comb begin
        state_d      = state_q;
        ext_req_d    = ext_req_q;
        ext_we_d     = ext_we_q;
        ext_adr_d    = ext_adr_q;
        ext_wdata_d  = ext_wdata_q;
        core_ack_d   = 1'b0;
        core_rdata_d = core_rdata_q;
        lo_buf_d     = lo_buf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.CoreReq) begin
                    if (bus.CoreWrite) begin
                        state_d     = WR;
                        ext_req_d   = 1'b1;
                        ext_we_d    = 1'b1;
                        ext_adr_d   = {bus.CoreAdr, LO_BYTE};
                        ext_wdata_d = bus.CoreWData;
                    end else if (cache_hit) begin
                        state_d      = RESP;
                        core_ack_d   = 1'b1;
                        core_rdata_d = cache_word;
                    end else begin
                        state_d   = RD_LO;
                        ext_req_d = 1'b1;
                        ext_we_d  = 1'b0;
                        ext_adr_d = {bus.CoreAdr, LO_BYTE};
                    end
                end
            end
            RD_LO: begin
                if (ext_done) begin
                    state_d   = RD_HI;
                    lo_buf_d  = bus.ExtRData;
                    ext_adr_d = {bus.CoreAdr, HI_BYTE};
                end
            end
            RD_HI: begin
                if (ext_done) begin
                    state_d      = RESP;
                    ext_req_d    = 1'b0;
                    core_ack_d   = 1'b1;
                    core_rdata_d = read_word;
                end
            end
            WR: begin
                if (ext_done) begin
                    state_d    = RESP;
                    ext_req_d  = 1'b0;
                    ext_we_d   = 1'b0;
                    core_ack_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                ext_req_d = 1'b0;
                ext_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ext_req_q    <= 1'b0;
            ext_we_q     <= 1'b0;
            ext_adr_q    <= '0;
            ext_wdata_q  <= '0;
            core_ack_q   <= 1'b0;
            core_rdata_q <= '0;
            lo_buf_q     <= '0;
        end else begin
            state_q      <= state_d;
            ext_req_q    <= ext_req_d;
            ext_we_q     <= ext_we_d;
            ext_adr_q    <= ext_adr_d;
            ext_wdata_q  <= ext_wdata_d;
            core_ack_q   <= core_ack_d;
            core_rdata_q <= core_rdata_d;
            lo_buf_q     <= lo_buf_d;
        end
    end

    assign bus.ExtReq    = ext_req_q;
    assign bus.ExtWE     = ext_we_q;
    assign bus.ExtAdr    = ext_adr_q;
    assign bus.ExtWData  = ext_wdata_q;
    assign bus.CoreAck   = core_ack_q;
    assign bus.CoreRData = core_rdata_q;

endmodule

`default_nettype wire
